hpdcache_refill_victim_ctrl: RTL and testbench



---
 rtl/hpdcache_refill_victim_ctrl_pkg.sv | 26 ++
 rtl/hpdcache_refill_victim_ctrl_checker.sv | 55 +++++
 rtl/hpdcache_refill_victim_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_hpdcache_refill_victim_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_refill_victim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_refill_victim_ctrl_pkg
//   Shared constants and helpers for the refill/victim controller.
//   - RETRY_CNT_W / retry_cnt_t : width and type of the no-victim retry counter
//   - retry_sat_inc()           : saturating increment of that counter
// -----------------------------------------------------------------------------
package hpdcache_refill_victim_ctrl_pkg;

  localparam int unsigned RETRY_CNT_W = 8;

  typedef logic [RETRY_CNT_W-1:0] retry_cnt_t;

  localparam retry_cnt_t RETRY_CNT_MAX = {RETRY_CNT_W{1'b1}};

  // Increment that sticks at the maximum instead of wrapping to zero.
  function automatic retry_cnt_t retry_sat_inc(input retry_cnt_t cnt);
    retry_cnt_t res;
    if (cnt == RETRY_CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + retry_cnt_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/hpdcache_refill_victim_ctrl_checker.sv
// -----------------------------------------------------------------------------
// hpdcache_refill_victim_ctrl_checker
//   Protocol properties for the refill/victim controller.
//   Ports:
//     clk_i, rst_ni                       clock, async active-low reset
//     in_select / in_wait                 controller is in SELECT / WAIT
//     sel_victim_way                      victim vector from the selector
//     refill_done                         refill completion pulse
//     evict_* / refill_*                  request handshakes being watched
// -----------------------------------------------------------------------------
module hpdcache_refill_victim_ctrl_checker #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SET_W = 6
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             in_select,
  input logic             in_wait,
  input logic [WAYS-1:0]  sel_victim_way,
  input logic             refill_done,
  input logic             evict_valid,
  input logic             evict_ready,
  input logic [SET_W-1:0] evict_set,
  input logic [WAYS-1:0]  evict_way,
  input logic             refill_valid,
  input logic             refill_ready,
  input logic [SET_W-1:0] refill_set,
  input logic [WAYS-1:0]  refill_way
);

  // The selector may name at most one victim way.
  a_victim_onehot0: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    in_select |-> $onehot0(sel_victim_way)
  ) else $error("victim vector is not one-hot or zero");

  // A completion pulse outside WAIT has no effect on the controller; report it.
  a_done_in_wait: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    refill_done |-> in_wait
  ) else $warning("refill_done_i seen outside WAIT and ignored");

  // An evict request held without ready keeps its payload.
  a_evict_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (evict_valid && !evict_ready) |=> (evict_valid && $stable(evict_set) && $stable(evict_way))
  ) else $error("evict request changed while stalled");

  // A refill request held without ready keeps its payload.
  a_refill_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (refill_valid && !refill_ready) |=> (refill_valid && $stable(refill_set) && $stable(refill_way))
  ) else $error("refill request changed while stalled");

endmodule

// File: rtl/hpdcache_refill_victim_ctrl.sv
// -----------------------------------------------------------------------------
// hpdcache_refill_victim_ctrl
//   Single-outstanding miss refill controller for one cache set: reads the
//   directory, hands it to the PLRU victim selector, reserves the chosen way,
//   writes back a dirty victim, requests the refill, waits for it and finally
//   signals the replacement event to the PLRU.
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     req_*                         miss request handshake (ready only in IDLE)
//     dir_rd_o, dir_rd_set_o        directory read, data back next cycle
//     dir_*_i                       directory bits of the read set
//     sel_*                         victim selector interface
//     fetch_mark_*                  reserve the victim way (fetch bit)
//     evict_*                       dirty-victim writeback request
//     refill_*                      memory refill request / completion
//     repl_*                        replacement event to the PLRU
//     busy_o, retry_cnt_o           status
// -----------------------------------------------------------------------------
module hpdcache_refill_victim_ctrl
  import hpdcache_refill_victim_ctrl_pkg::*;
#(
  parameter int unsigned SETS = 64,
  parameter int unsigned WAYS = 4,
  localparam int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [SET_W-1:0]       req_set_i,

  output logic                   dir_rd_o,
  output logic [SET_W-1:0]       dir_rd_set_o,
  input  logic [WAYS-1:0]        dir_valid_i,
  input  logic [WAYS-1:0]        dir_wback_i,
  input  logic [WAYS-1:0]        dir_dirty_i,
  input  logic [WAYS-1:0]        dir_fetch_i,

  output logic [WAYS-1:0]        sel_dir_valid_o,
  output logic [WAYS-1:0]        sel_dir_wback_o,
  output logic [WAYS-1:0]        sel_dir_dirty_o,
  output logic [WAYS-1:0]        sel_dir_fetch_o,
  output logic [SET_W-1:0]       sel_victim_set_o,
  input  logic [WAYS-1:0]        sel_victim_way_i,

  output logic                   fetch_mark_o,
  output logic [SET_W-1:0]       fetch_mark_set_o,
  output logic [WAYS-1:0]        fetch_mark_way_o,

  output logic                   evict_valid_o,
  input  logic                   evict_ready_i,
  output logic [SET_W-1:0]       evict_set_o,
  output logic [WAYS-1:0]        evict_way_o,

  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  output logic [SET_W-1:0]       refill_set_o,
  output logic [WAYS-1:0]        refill_way_o,
  input  logic                   refill_done_i,

  output logic                   repl_o,
  output logic [SET_W-1:0]       repl_set_o,
  output logic [WAYS-1:0]        repl_way_o,

  output logic                   busy_o,
  output logic [RETRY_CNT_W-1:0] retry_cnt_o
);

  typedef logic [SET_W-1:0] set_t;
  typedef logic [WAYS-1:0]  way_vector_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIR_RD = 3'd1,
    ST_SELECT = 3'd2,
    ST_EVICT  = 3'd3,
    ST_FETCH  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_REPL   = 3'd6
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  set_t        set_r;
  way_vector_t way_r;
  retry_cnt_t  retry_cnt_r;

  logic        set_ld_s;
  logic        way_ld_s;
  logic        retry_inc_s;
  logic        in_select_s;
  logic        victim_none_s;
  logic        victim_dirty_s;

  assign in_select_s    = (state_r == ST_SELECT);
  assign victim_none_s  = (sel_victim_way_i == {WAYS{1'b0}});
  // Only a valid, dirty, write-back line needs to be written out before reuse.
  assign victim_dirty_s = |(sel_victim_way_i & dir_valid_i & dir_dirty_i & dir_wback_i);

  // State register, latched set/way and saturating retry counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      set_r       <= {SET_W{1'b0}};
      way_r       <= {WAYS{1'b0}};
      retry_cnt_r <= {RETRY_CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (set_ld_s) begin
        set_r <= req_set_i;
      end
      if (way_ld_s) begin
        way_r <= sel_victim_way_i;
      end
      if (retry_inc_s) begin
        retry_cnt_r <= retry_sat_inc(retry_cnt_r);
      end
    end
  end

  // Next-state decode and register load enables.
  always_comb begin
    state_next_s = state_r;
    set_ld_s     = 1'b0;
    way_ld_s     = 1'b0;
    retry_inc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          set_ld_s     = 1'b1;
          state_next_s = ST_DIR_RD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DIR_RD: begin
        state_next_s = ST_SELECT;
      end
      ST_SELECT: begin
        if (victim_none_s) begin
          // Every way is busy or reserved: re-read the directory and try again.
          retry_inc_s  = 1'b1;
          state_next_s = ST_DIR_RD;
        end else if (victim_dirty_s) begin
          way_ld_s     = 1'b1;
          state_next_s = ST_EVICT;
        end else begin
          way_ld_s     = 1'b1;
          state_next_s = ST_FETCH;
        end
      end
      ST_EVICT: begin
        if (evict_ready_i) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_EVICT;
        end
      end
      ST_FETCH: begin
        if (refill_ready_i) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (refill_done_i) begin
          state_next_s = ST_REPL;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_REPL: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Strobes are qualified by state; set/way buses always carry the latched values.
  assign req_ready_o      = (state_r == ST_IDLE);
  assign busy_o           = (state_r != ST_IDLE);
  assign retry_cnt_o      = retry_cnt_r;

  assign dir_rd_o         = (state_r == ST_DIR_RD);
  assign dir_rd_set_o     = set_r;

  assign sel_dir_valid_o  = in_select_s ? dir_valid_i : {WAYS{1'b0}};
  assign sel_dir_wback_o  = in_select_s ? dir_wback_i : {WAYS{1'b0}};
  assign sel_dir_dirty_o  = in_select_s ? dir_dirty_i : {WAYS{1'b0}};
  assign sel_dir_fetch_o  = in_select_s ? dir_fetch_i : {WAYS{1'b0}};
  assign sel_victim_set_o = set_r;

  // The way is not latched yet while the mark is pulsed, so pass the selector through.
  assign fetch_mark_o     = in_select_s & ~victim_none_s;
  assign fetch_mark_set_o = set_r;
  assign fetch_mark_way_o = in_select_s ? sel_victim_way_i : way_r;

  assign evict_valid_o    = (state_r == ST_EVICT);
  assign evict_set_o      = set_r;
  assign evict_way_o      = way_r;

  assign refill_valid_o   = (state_r == ST_FETCH);
  assign refill_set_o     = set_r;
  assign refill_way_o     = way_r;

  assign repl_o           = (state_r == ST_REPL);
  assign repl_set_o       = set_r;
  assign repl_way_o       = way_r;

  hpdcache_refill_victim_ctrl_checker #(
    .WAYS  (WAYS),
    .SET_W (SET_W)
  ) u_checker (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_select      (in_select_s),
    .in_wait        (state_r == ST_WAIT),
    .sel_victim_way (sel_victim_way_i),
    .refill_done    (refill_done_i),
    .evict_valid    (evict_valid_o),
    .evict_ready    (evict_ready_i),
    .evict_set      (evict_set_o),
    .evict_way      (evict_way_o),
    .refill_valid   (refill_valid_o),
    .refill_ready   (refill_ready_i),
    .refill_set     (refill_set_o),
    .refill_way     (refill_way_o)
  );

endmodule

// File: tb/tb_hpdcache_refill_victim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_refill_victim_ctrl
//   Directed bench with a phase-level reference model checked every cycle,
//   plus literal expectations at the points called out for each scenario.
// -----------------------------------------------------------------------------
module tb_hpdcache_refill_victim_ctrl;

  localparam int unsigned SETS = 8;
  localparam int unsigned WAYS = 4;
  localparam int unsigned SW   = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [SW-1:0]   req_set_i;
  logic            dir_rd_o;
  logic [SW-1:0]   dir_rd_set_o;
  logic [WAYS-1:0] dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i;
  logic [WAYS-1:0] sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o;
  logic [SW-1:0]   sel_victim_set_o;
  logic [WAYS-1:0] sel_victim_way_i;
  logic            fetch_mark_o;
  logic [SW-1:0]   fetch_mark_set_o;
  logic [WAYS-1:0] fetch_mark_way_o;
  logic            evict_valid_o, evict_ready_i;
  logic [SW-1:0]   evict_set_o;
  logic [WAYS-1:0] evict_way_o;
  logic            refill_valid_o, refill_ready_i, refill_done_i;
  logic [SW-1:0]   refill_set_o;
  logic [WAYS-1:0] refill_way_o;
  logic            repl_o;
  logic [SW-1:0]   repl_set_o;
  logic [WAYS-1:0] repl_way_o;
  logic            busy_o;
  logic [7:0]      retry_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  hpdcache_refill_victim_ctrl #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
    .dir_rd_o(dir_rd_o), .dir_rd_set_o(dir_rd_set_o),
    .dir_valid_i(dir_valid_i), .dir_wback_i(dir_wback_i),
    .dir_dirty_i(dir_dirty_i), .dir_fetch_i(dir_fetch_i),
    .sel_dir_valid_o(sel_dir_valid_o), .sel_dir_wback_o(sel_dir_wback_o),
    .sel_dir_dirty_o(sel_dir_dirty_o), .sel_dir_fetch_o(sel_dir_fetch_o),
    .sel_victim_set_o(sel_victim_set_o), .sel_victim_way_i(sel_victim_way_i),
    .fetch_mark_o(fetch_mark_o), .fetch_mark_set_o(fetch_mark_set_o),
    .fetch_mark_way_o(fetch_mark_way_o),
    .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
    .evict_set_o(evict_set_o), .evict_way_o(evict_way_o),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_set_o(refill_set_o), .refill_way_o(refill_way_o),
    .refill_done_i(refill_done_i),
    .repl_o(repl_o), .repl_set_o(repl_set_o), .repl_way_o(repl_way_o),
    .busy_o(busy_o), .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase names from the operation description)
  string           m_phase;
  logic [SW-1:0]   m_set;
  logic [WAYS-1:0] m_way;
  int              m_retry;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase <= "IDLE";
      m_set   <= '0;
      m_way   <= '0;
      m_retry <= 0;
    end else if (m_phase == "IDLE") begin
      if (req_valid_i) begin
        m_set   <= req_set_i;
        m_phase <= "DIR_RD";
      end
    end else if (m_phase == "DIR_RD") begin
      m_phase <= "SELECT";
    end else if (m_phase == "SELECT") begin
      if (sel_victim_way_i == 0) begin
        m_retry <= (m_retry + 1 > 255) ? 255 : m_retry + 1;
        m_phase <= "DIR_RD";
      end else begin
        m_way   <= sel_victim_way_i;
        m_phase <= ((sel_victim_way_i & dir_valid_i & dir_dirty_i & dir_wback_i) != 0)
                   ? "EVICT" : "FETCH";
      end
    end else if (m_phase == "EVICT") begin
      if (evict_ready_i) m_phase <= "FETCH";
    end else if (m_phase == "FETCH") begin
      if (refill_ready_i) m_phase <= "WAIT";
    end else if (m_phase == "WAIT") begin
      if (refill_done_i) m_phase <= "REPL";
    end else begin
      m_phase <= "IDLE";
    end
  end

  // ---------------- per-cycle comparison, away from the active edge
  logic in_sel;
  always @(negedge clk_i) begin
    if (chk_en) begin
      in_sel = (m_phase == "SELECT");
      check("req_ready", int'(req_ready_o), int'(m_phase == "IDLE"));
      check("busy", int'(busy_o), int'(m_phase != "IDLE"));
      check("dir_rd", int'(dir_rd_o), int'(m_phase == "DIR_RD"));
      check("dir_rd_set", int'(dir_rd_set_o), int'(m_set));
      check("sel_dir_valid", int'(sel_dir_valid_o), in_sel ? int'(dir_valid_i) : 0);
      check("sel_dir_wback", int'(sel_dir_wback_o), in_sel ? int'(dir_wback_i) : 0);
      check("sel_dir_dirty", int'(sel_dir_dirty_o), in_sel ? int'(dir_dirty_i) : 0);
      check("sel_dir_fetch", int'(sel_dir_fetch_o), in_sel ? int'(dir_fetch_i) : 0);
      check("sel_victim_set", int'(sel_victim_set_o), int'(m_set));
      check("fetch_mark", int'(fetch_mark_o), int'(in_sel && sel_victim_way_i != 0));
      check("fetch_mark_set", int'(fetch_mark_set_o), int'(m_set));
      check("fetch_mark_way", int'(fetch_mark_way_o), in_sel ? int'(sel_victim_way_i) : int'(m_way));
      check("evict_valid", int'(evict_valid_o), int'(m_phase == "EVICT"));
      check("evict_set", int'(evict_set_o), int'(m_set));
      check("evict_way", int'(evict_way_o), int'(m_way));
      check("refill_valid", int'(refill_valid_o), int'(m_phase == "FETCH"));
      check("refill_set", int'(refill_set_o), int'(m_set));
      check("refill_way", int'(refill_way_o), int'(m_way));
      check("repl", int'(repl_o), int'(m_phase == "REPL"));
      check("repl_set", int'(repl_set_o), int'(m_set));
      check("repl_way", int'(repl_way_o), int'(m_way));
      check("retry_cnt", int'(retry_cnt_o), m_retry);
    end
  end

  // ---------------- stimulus helpers: inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Advance until the refill request is issued, then one more edge into WAIT.
  task automatic to_wait();
    int n;
    n = 0;
    refill_ready_i = 1'b1;
    evict_ready_i  = 1'b1;
    while (!refill_valid_o && n < 2000) begin
      tick();
      n++;
    end
    check("refill_req_timeout", int'(refill_valid_o), 1);
    tick();
  endtask

  task automatic finish_fill(input int exp_set, input int exp_way, input string tag);
    to_wait();
    refill_done_i = 1'b1;
    tick();
    refill_done_i = 1'b0;
    check({tag, "_repl"}, int'(repl_o), 1);
    check({tag, "_repl_set"}, int'(repl_set_o), exp_set);
    check({tag, "_repl_way"}, int'(repl_way_o), exp_way);
    tick();
    check({tag, "_idle_after"}, int'(req_ready_o), 1);
  endtask

  initial begin
    req_valid_i = 1'b0; req_set_i = '0;
    dir_valid_i = '0; dir_wback_i = '0; dir_dirty_i = '0; dir_fetch_i = '0;
    sel_victim_way_i = '0;
    evict_ready_i = 1'b1; refill_ready_i = 1'b1; refill_done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // Reset state
    check("rst_req_ready", int'(req_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_retry", int'(retry_cnt_o), 0);
    check("rst_repl", int'(repl_o), 0);
    check("rst_evict_valid", int'(evict_valid_o), 0);

    // Clean fill, set 3, best-case latency
    sel_victim_way_i = 4'b0001; req_set_i = 3'd3; req_valid_i = 1'b1;   // cycle 0
    tick(); req_valid_i = 1'b0;                                          // cycle 1
    check("t1_dir_rd", int'(dir_rd_o), 1);
    check("t1_dir_rd_set", int'(dir_rd_set_o), 3);
    tick();                                                              // cycle 2
    check("t1_fetch_mark", int'(fetch_mark_o), 1);
    check("t1_fetch_mark_way", int'(fetch_mark_way_o), 1);
    tick();                                                              // cycle 3
    check("t1_refill_valid", int'(refill_valid_o), 1);
    check("t1_no_evict", int'(evict_valid_o), 0);
    tick(); refill_done_i = 1'b1;                                        // cycle 4
    tick(); refill_done_i = 1'b0;                                        // cycle 5
    check("t1_repl", int'(repl_o), 1);
    check("t1_repl_set", int'(repl_set_o), 3);
    check("t1_repl_way", int'(repl_way_o), 1);
    tick();                                                              // cycle 6
    check("t1_ready_again", int'(req_ready_o), 1);

    // Dirty victim with writeback back-pressure, set 5
    dir_valid_i = 4'b1111; dir_dirty_i = 4'b0100; dir_wback_i = 4'b0100;
    sel_victim_way_i = 4'b0100; evict_ready_i = 1'b0;
    req_set_i = 3'd5; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    tick();
    check("t2_fetch_mark_way", int'(fetch_mark_way_o), 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_evict_valid", int'(evict_valid_o), 1);
      check("t2_evict_way", int'(evict_way_o), 4);
      check("t2_evict_set", int'(evict_set_o), 5);
      check("t2_no_refill_yet", int'(refill_valid_o), 0);
    end
    evict_ready_i = 1'b1;
    tick();
    check("t2_refill_after_evict", int'(refill_valid_o), 1);
    finish_fill(5, 4, "t2");
    dir_valid_i = '0; dir_dirty_i = '0; dir_wback_i = '0;

    // No victim twice, then success, set 6
    dir_fetch_i = 4'b1111; sel_victim_way_i = 4'b0000;
    req_set_i = 3'd6; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;          // DIR_RD
    tick(); tick(); tick();              // SELECT, DIR_RD, SELECT
    tick();                              // DIR_RD again
    check("t3_retry_two", int'(retry_cnt_o), 2);
    check("t3_reread", int'(dir_rd_o), 1);
    dir_fetch_i = 4'b0000; sel_victim_way_i = 4'b0001;
    finish_fill(6, 1, "t3");

    // Retry saturation
    sel_victim_way_i = 4'b0000; req_set_i = 3'd1; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    repeat (600) tick();
    check("t4_retry_sat", int'(retry_cnt_o), 255);
    sel_victim_way_i = 4'b0010;
    finish_fill(1, 2, "t4");
    check("t4_retry_held", int'(retry_cnt_o), 255);

    // Request held while busy, spurious done in FETCH, set 2
    sel_victim_way_i = 4'b0010; req_set_i = 3'd2; req_valid_i = 1'b1; refill_ready_i = 1'b0;
    tick(); check("t5_busy_ready0_a", int'(req_ready_o), 0);
    tick(); check("t5_busy_ready0_b", int'(req_ready_o), 0);
    tick();
    check("t5_in_fetch", int'(refill_valid_o), 1);
    refill_done_i = 1'b1;
    tick(); refill_done_i = 1'b0;
    check("t5_done_ignored", int'(refill_valid_o), 1);
    check("t5_no_repl", int'(repl_o), 0);
    refill_ready_i = 1'b1;
    tick(); check("t5_wait_ready0", int'(req_ready_o), 0);
    refill_done_i = 1'b1;
    tick(); refill_done_i = 1'b0;
    check("t5_repl", int'(repl_o), 1);
    check("t5_repl_ready0", int'(req_ready_o), 0);
    tick(); check("t5_ready_after_repl", int'(req_ready_o), 1);
    tick(); req_valid_i = 1'b0;
    check("t5_second_accepted", int'(busy_o), 1);
    finish_fill(2, 2, "t5b");

    // Reset in WAIT, then a normal fill
    sel_victim_way_i = 4'b1000; req_set_i = 3'd7; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    to_wait();
    rst_ni = 1'b0;
    tick();
    check("t6_rst_busy", int'(busy_o), 0);
    check("t6_rst_ready", int'(req_ready_o), 1);
    check("t6_rst_repl", int'(repl_o), 0);
    check("t6_rst_refill", int'(refill_valid_o), 0);
    check("t6_rst_retry", int'(retry_cnt_o), 0);
    check("t6_rst_way", int'(repl_way_o), 0);
    rst_ni = 1'b1;
    sel_victim_way_i = 4'b0010; req_set_i = 3'd1; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    finish_fill(1, 2, "t6");

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
